// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipeline hazard unit.
// FSM state encoding, register-zero constant, default cycle counts.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } hz_state_e;

  localparam int REG_ZERO         = 0;
  localparam int DEF_LD_STALL_CYC = 1;
  localparam int DEF_DRAIN_CYC    = 3;

endpackage

// File: rtl/pipe_hazard_perf_cnt.sv
// 16-bit saturating event counter for hazard statistics.
// Only built when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // count up on each event, hold once all ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt controller for the 5-stage pipeline.
// HAZARD_PERF_EN adds saturating stall/flush/cycle counters.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int LD_STALL_CYC = DEF_LD_STALL_CYC,
  parameter int DRAIN_CYC    = DEF_DRAIN_CYC,
  parameter int REG_AW       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_jump,
  input  logic              id_hlt,
  input  logic              ex_memRd,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_pcSrc,
  output logic              pc_en,
  output logic              IF_ID_en,
  output logic              ID_EX_en,
  output logic              EX_MEM_en,
  output logic              MEM_WB_en,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              EX_MEM_flush,
  output logic              hlt
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       perf_stall,
  output logic [15:0]       perf_flush,
  output logic [15:0]       perf_cyc
`endif
);

  localparam int SW = 2;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [SW-1:0] STALL_LD = SW'(LD_STALL_CYC - 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYC - 1);

  hz_state_e     state_q;
  hz_state_e     state_d;
  logic [SW-1:0] stall_cnt_q;
  logic [SW-1:0] stall_cnt_d;
  logic [DW-1:0] drain_cnt_q;
  logic [DW-1:0] drain_cnt_d;
  logic          lu;

  // load in EX feeding a source of ID; r0 never hazards
  assign lu = ex_memRd
            && (ex_rd != REG_AW'(REG_ZERO))
            && ((id_use_rs1 && (id_rs1 == ex_rd))
             || (id_use_rs2 && (id_rs2 == ex_rd)));

  // next state, counters and pipeline controls
  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    pc_en        = 1'b1;
    IF_ID_en     = 1'b1;
    ID_EX_en     = 1'b1;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    hlt          = 1'b0;

    if ((state_q != HALTED) && mem_pcSrc) begin
      // taken branch kills everything younger, incl. stalls/halts
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      stall_cnt_d  = '0;
      drain_cnt_d  = '0;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
            stall_cnt_d = STALL_LD;
            state_d     = (STALL_LD != '0) ? STALL : RUN;
          end else if (id_hlt) begin
            pc_en       = 1'b0;
            IF_ID_flush = 1'b1;
            drain_cnt_d = DRAIN_LD;
            state_d     = (DRAIN_LD != '0) ? DRAIN : HALTED;
          end else if (id_jump) begin
            IF_ID_flush = 1'b1;
          end
        end
        STALL: begin
          pc_en       = 1'b0;
          IF_ID_en    = 1'b0;
          ID_EX_flush = 1'b1;
          stall_cnt_d = stall_cnt_q - SW'(1);
          if (stall_cnt_q <= SW'(1)) begin
            stall_cnt_d = '0;
            state_d     = RUN;
          end
        end
        DRAIN: begin
          pc_en       = 1'b0;
          IF_ID_flush = 1'b1;
          drain_cnt_d = drain_cnt_q - DW'(1);
          if (drain_cnt_q <= DW'(1)) begin
            drain_cnt_d = '0;
            state_d     = HALTED;
          end
        end
        HALTED: begin
          pc_en     = 1'b0;
          IF_ID_en  = 1'b0;
          ID_EX_en  = 1'b0;
          EX_MEM_en = 1'b0;
          MEM_WB_en = 1'b0;
          hlt       = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    // a flushed register is written with a bubble
    IF_ID_en  = IF_ID_en  | IF_ID_flush;
    ID_EX_en  = ID_EX_en  | ID_EX_flush;
    EX_MEM_en = EX_MEM_en | EX_MEM_flush;
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_ev;
  logic flush_ev;
  logic cyc_ev;

  assign stall_ev = !mem_pcSrc
                 && (((state_q == RUN) && lu)
                  || (state_q == STALL));
  assign flush_ev = (state_q != HALTED)
                 && (mem_pcSrc
                  || ((state_q == RUN) && id_jump
                   && !lu && !id_hlt));
  assign cyc_ev   = (state_q != HALTED);

  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_ev),
    .cnt_o (perf_stall)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_ev),
    .cnt_o (perf_flush)
  );

  hazard_perf_cnt u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (cyc_ev),
    .cnt_o (perf_cyc)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (LD_STALL_CYC 1 and 3).
// Both instances share stimulus; expectations are hand-derived.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rs1, rs2, exrd;
  logic       use1, use2, jump, hltin, memrd, pcsrc;

  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb;
  logic a_fifid, a_fidex, a_fexmem, a_hlt;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb;
  logic b_fifid, b_fidex, b_fexmem, b_hlt;
`ifdef HAZARD_PERF_EN
  logic [15:0] a_pst, a_pfl, a_pcy;
  logic [15:0] b_pst, b_pfl, b_pcy;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk (clk), .rst_n (rst_n),
    .id_rs1 (rs1), .id_rs2 (rs2),
    .id_use_rs1 (use1), .id_use_rs2 (use2),
    .id_jump (jump), .id_hlt (hltin),
    .ex_memRd (memrd), .ex_rd (exrd),
    .mem_pcSrc (pcsrc),
    .pc_en (a_pc), .IF_ID_en (a_ifid),
    .ID_EX_en (a_idex), .EX_MEM_en (a_exmem),
    .MEM_WB_en (a_memwb),
    .IF_ID_flush (a_fifid), .ID_EX_flush (a_fidex),
    .EX_MEM_flush (a_fexmem), .hlt (a_hlt)
`ifdef HAZARD_PERF_EN
    , .perf_stall (a_pst), .perf_flush (a_pfl),
    .perf_cyc (a_pcy)
`endif
  );

  pipe_hazard_ctrl #(.LD_STALL_CYC (3)) u_dut3 (
    .clk (clk), .rst_n (rst_n),
    .id_rs1 (rs1), .id_rs2 (rs2),
    .id_use_rs1 (use1), .id_use_rs2 (use2),
    .id_jump (jump), .id_hlt (hltin),
    .ex_memRd (memrd), .ex_rd (exrd),
    .mem_pcSrc (pcsrc),
    .pc_en (b_pc), .IF_ID_en (b_ifid),
    .ID_EX_en (b_idex), .EX_MEM_en (b_exmem),
    .MEM_WB_en (b_memwb),
    .IF_ID_flush (b_fifid), .ID_EX_flush (b_fidex),
    .EX_MEM_flush (b_fexmem), .hlt (b_hlt)
`ifdef HAZARD_PERF_EN
    , .perf_stall (b_pst), .perf_flush (b_pfl),
    .perf_cyc (b_pcy)
`endif
  );

  // {pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, hlt}
  wire [8:0] o1 = {a_pc, a_ifid, a_idex, a_exmem, a_memwb,
                   a_fifid, a_fidex, a_fexmem, a_hlt};
  wire [8:0] o3 = {b_pc, b_ifid, b_idex, b_exmem, b_memwb,
                   b_fifid, b_fidex, b_fexmem, b_hlt};

  localparam logic [8:0] NORM = 9'b1_1111_000_0;
  localparam logic [8:0] LU   = 9'b0_0111_010_0;
  localparam logic [8:0] JMP  = 9'b1_1111_100_0;
  localparam logic [8:0] HLTD = 9'b0_1111_100_0;
  localparam logic [8:0] BR   = 9'b1_1111_111_0;
  localparam logic [8:0] HALT = 9'b0_0000_000_1;

  typedef struct {
    string      tag;
    logic [8:0] e1;
    logic [8:0] e3;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; exrd = '0;
    use1 = 0; use2 = 0; jump = 0;
    hltin = 0; memrd = 0; pcsrc = 0;
  endtask

  task automatic set_lu(input logic [3:0] r);
    memrd = 1; exrd = r; rs1 = r; use1 = 1;
  endtask

  task automatic push_exp(input string tag,
                          input logic [8:0] e1,
                          input logic [8:0] e3);
    exp_t e;
    e.tag = tag; e.e1 = e1; e.e3 = e3;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "/ld1"}, 32'(o1), 32'(e.e1));
      check({e.tag, "/ld3"}, 32'(o3), 32'(e.e3));
    end
  endtask

  task automatic step(input string tag,
                      input logic [8:0] e1,
                      input logic [8:0] e3);
    push_exp(tag, e1, e3);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", NORM, NORM);
    @(negedge clk);
    pop_cmp();
    rst_n = 1;
    @(posedge clk);
    #1;

    idle(); step("idle", NORM, NORM);
    set_lu(3); step("lu", LU, LU);
    idle(); step("lu_s1", NORM, LU);
    step("lu_s2", NORM, LU);
    step("lu_done", NORM, NORM);

    memrd = 1; exrd = 0; rs1 = 0; use1 = 1;
    step("r0", NORM, NORM);

    idle(); memrd = 1; exrd = 5; rs2 = 5; use2 = 1;
    step("lu_rs2", LU, LU);
    idle(); pcsrc = 1; step("br_stall", BR, BR);
    idle(); step("br_after", NORM, NORM);

    idle(); set_lu(7); jump = 1;
    step("jmp_lu", LU, LU);
    idle(); jump = 1;
    step("jmp_1", JMP, LU);
    step("jmp_2", JMP, LU);
    step("jmp_3", JMP, JMP);

    idle(); set_lu(2); hltin = 1;
    step("hlt_lu", LU, LU);
    idle(); hltin = 1;
    step("hlt_1", HLTD, LU);
    step("hlt_2", HLTD, LU);
    step("hlt_3", HLTD, HLTD);
    idle();
    step("hlt_4", HALT, HLTD);
    step("hlt_5", HALT, HLTD);
    for (int i = 0; i < 10; i++) begin
      idle();
      pcsrc = i[0];
      if (i[1]) set_lu(6);
      jump = i[2];
      hltin = i[3];
      step("halted", HALT, HALT);
    end

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle(); set_lu(4);
    step("lu_pre_rst", LU, LU);
`ifdef HAZARD_PERF_EN
    check("pst/ld1", 32'(a_pst), 32'd1);
    check("pst/ld3", 32'(b_pst), 32'd1);
`endif
    idle();
    step("stall_mid", NORM, LU);
    rst_n = 0;
    push_exp("rst_async", NORM, NORM);
    #1;
    pop_cmp();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    idle(); hltin = 1;
    step("wp_hlt", HLTD, HLTD);
    idle(); step("wp_d1", HLTD, HLTD);
    pcsrc = 1; step("wp_br", BR, BR);
    idle();
    repeat (4) step("wp_run", NORM, NORM);
`ifdef HAZARD_PERF_EN
    check("pfl/ld1", 32'(a_pfl), 32'd1);
    check("pfl/ld3", 32'(b_pfl), 32'd1);
    check("pst0/ld1", 32'(a_pst), 32'd0);
    check("pcy/ld1", 32'(a_pcy), 32'd8);
    check("pcy/ld3", 32'(b_pcy), 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
